// File: rtl/demux_pkg.sv
// Shared types for the round-robin demux scheduler: channel count, select type
// and FSM state encoding.
package demux_pkg;

  localparam int CH_N = 4;

  typedef logic [1:0] chan_sel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic logic [CH_N-1:0] sel_onehot(input chan_sel_t sel);
    sel_onehot      = '0;
    sel_onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first enabled channel after the last one
// served, wrapping around so the last-served channel is considered last.
module rr_pick
  import demux_pkg::*;
(
  input  logic [CH_N-1:0] mask,
  input  chan_sel_t       last,
  output chan_sel_t       grant,
  output logic            grant_valid
);

  chan_sel_t cand;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    cand        = last;
    for (int off = 1; off <= CH_N; off++) begin
      cand = last + 2'(off);
      if (!grant_valid && mask[cand]) begin
        grant       = cand;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_rr_scheduler.sv
// Burst scheduler in front of a 1-to-4 demux: routes BURST_LEN beats to one
// enabled channel at a time through a one-entry registered output stage.
module demux_rr_scheduler
  import demux_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_N-1:0]   en_mask,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_N-1:0]   out_valid,
  input  logic [CH_N-1:0]   out_ready,
  output chan_sel_t         cur_sel,
  output logic              busy
);

  localparam int               CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] beat_cnt;
  chan_sel_t        last_sel;
  chan_sel_t        grant;
  logic             grant_valid;
  logic             hold_full;
  logic             accept;
  logic             drain;

  rr_pick u_pick (
    .mask        (en_mask),
    .last        (last_sel),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  assign drain     = hold_full && out_ready[cur_sel];
  assign accept    = in_valid && in_ready;
  assign busy      = (state != IDLE);
  assign out_valid = hold_full ? sel_onehot(cur_sel) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // in_ready depends only on state, hold status and the owning channel's ready,
  // so a drain and a new accept can share one cycle without a path from in_valid.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_valid) state_next = XFER;
      end
      XFER: begin
        in_ready = !hold_full || out_ready[cur_sel];
        if (in_valid && in_ready && (beat_cnt == LAST_BEAT)) state_next = DRAIN;
      end
      DRAIN: begin
        if (!hold_full || drain) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_sel  <= '0;
      last_sel <= 2'(CH_N - 1);
      beat_cnt <= '0;
    end else begin
      if ((state == IDLE) && grant_valid) begin
        cur_sel  <= grant;
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
      if ((state == DRAIN) && (state_next == IDLE)) last_sel <= cur_sel;
    end
  end

  // A same-cycle drain and accept simply replaces the held beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      out_data  <= '0;
    end else begin
      if (accept) begin
        hold_full <= 1'b1;
        out_data  <= in_data;
      end else if (drain) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Self-checking bench for demux_rr_scheduler: vector table, directed corner
// sequences and randomized traffic against a burst-level scoreboard.
module tb_demux_rr_scheduler;

  localparam int DATA_W = 8;
  localparam int BL     = 4;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic [DATA_W-1:0] in_data   = '0;
  logic              in_valid  = 1'b0;
  logic              in_ready;
  logic [3:0]        en_mask   = 4'h0;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready = 4'h0;
  logic [1:0]        cur_sel;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  demux_rr_scheduler #(.DATA_W(DATA_W), .BURST_LEN(BL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .en_mask   (en_mask),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cur_sel   (cur_sel),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [3:0] exp_valid;
    logic [7:0] exp_data;
    logic [1:0] exp_sel;
    logic       exp_ready;
    logic       exp_busy;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] ch;
  } beat_t;

  vec_t  vecs[13];
  beat_t pend[$];
  int    recv[4];
  int    burst_beats;
  logic [1:0] m_last;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkVec(logic [7:0] d, logic er, logic [3:0] ev, logic [7:0] ed,
                                 logic [1:0] es, logic eb);
    vec_t v;
    v.data      = d;
    v.exp_ready = er;
    v.exp_valid = ev;
    v.exp_data  = ed;
    v.exp_sel   = es;
    v.exp_busy  = eb;
    return v;
  endfunction

  // Next enabled channel strictly after 'last', wrapping; the spec's rotation rule.
  function automatic logic [1:0] pickNext(logic [1:0] last, logic [3:0] mask);
    for (int off = 1; off <= 4; off++) begin
      int c;
      c = (int'(last) + off) % 4;
      if (mask[c]) return 2'(c);
    end
    return last;
  endfunction

  task automatic modelReset();
    pend.delete();
    for (int i = 0; i < 4; i++) recv[i] = 0;
    burst_beats = 0;
    m_last      = 2'd3;
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 4'h0;
    en_mask   = 4'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  // Table row: inputs for one cycle, outputs checked just before the edge.
  task automatic applyStimulus(input int idx, input vec_t v);
    in_valid  = 1'b1;
    in_data   = v.data;
    en_mask   = 4'hf;
    out_ready = 4'hf;
    #1;
    checkOutput($sformatf("row%0d_in_ready", idx), in_ready, v.exp_ready);
    checkOutput($sformatf("row%0d_out_valid", idx), out_valid, v.exp_valid);
    checkOutput($sformatf("row%0d_out_data", idx), out_data, v.exp_data);
    checkOutput($sformatf("row%0d_cur_sel", idx), cur_sel, v.exp_sel);
    checkOutput($sformatf("row%0d_busy", idx), busy, v.exp_busy);
    @(negedge clk);
  endtask

  // One cycle against the scoreboard: beats queue up in acceptance order, each
  // burst of BL beats goes to the next enabled channel, and the output stage
  // must always present the oldest unconsumed beat.
  task automatic tick(input logic [7:0] d, input logic v, input logic [3:0] m,
                      input logic [3:0] r, output logic acc);
    logic cons;
    in_data   = d;
    in_valid  = v;
    en_mask   = m;
    out_ready = r;
    #1;
    if (pend.size() > 0) begin
      checkOutput("busy_while_holding", busy, 1);
      if (!r[pend[0].ch]) checkOutput("in_ready_stalled", in_ready, 0);
      if (burst_beats == BL) checkOutput("in_ready_burst_done", in_ready, 0);
    end
    acc  = v && in_ready;
    cons = (pend.size() > 0) && r[pend[0].ch];
    @(posedge clk);
    #1;
    if (cons) begin
      recv[pend[0].ch]++;
      void'(pend.pop_front());
    end
    if (acc) begin
      if (burst_beats == 0) m_last = pickNext(m_last, m);
      pend.push_back('{data: d, ch: m_last});
      burst_beats++;
    end
    if (burst_beats == BL && pend.size() == 0) burst_beats = 0;
    if (pend.size() > 0) begin
      checkOutput("out_valid", out_valid, 4'b0001 << pend[0].ch);
      checkOutput("out_data", out_data, pend[0].data);
      checkOutput("cur_sel", cur_sel, pend[0].ch);
    end else begin
      checkOutput("out_valid_empty", out_valid, 0);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic a;
    int   n;
    logic [3:0] m;

    vecs[0]  = mkVec(8'h00, 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
    vecs[1]  = mkVec(8'h00, 1'b1, 4'b0000, 8'h00, 2'd0, 1'b1);
    vecs[2]  = mkVec(8'h01, 1'b1, 4'b0001, 8'h00, 2'd0, 1'b1);
    vecs[3]  = mkVec(8'h02, 1'b1, 4'b0001, 8'h01, 2'd0, 1'b1);
    vecs[4]  = mkVec(8'h03, 1'b1, 4'b0001, 8'h02, 2'd0, 1'b1);
    vecs[5]  = mkVec(8'h04, 1'b0, 4'b0001, 8'h03, 2'd0, 1'b1);
    vecs[6]  = mkVec(8'h04, 1'b0, 4'b0000, 8'h03, 2'd0, 1'b0);
    vecs[7]  = mkVec(8'h04, 1'b1, 4'b0000, 8'h03, 2'd1, 1'b1);
    vecs[8]  = mkVec(8'h05, 1'b1, 4'b0010, 8'h04, 2'd1, 1'b1);
    vecs[9]  = mkVec(8'h06, 1'b1, 4'b0010, 8'h05, 2'd1, 1'b1);
    vecs[10] = mkVec(8'h07, 1'b1, 4'b0010, 8'h06, 2'd1, 1'b1);
    vecs[11] = mkVec(8'h08, 1'b0, 4'b0010, 8'h07, 2'd1, 1'b1);
    vecs[12] = mkVec(8'h08, 1'b0, 4'b0000, 8'h07, 2'd1, 1'b0);

    // Reset values, then the cycle-exact vector table for two bursts.
    doReset();
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_data", out_data, 0);
    checkOutput("reset_cur_sel", cur_sel, 0);
    checkOutput("reset_busy", busy, 0);
    for (int i = 0; i < 13; i++) applyStimulus(i, vecs[i]);

    $display("[TB] rotation over all channels");
    doReset();
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick(8'(n), 1'b1, 4'hf, 4'hf, a);
      if (a) n++;
    end
    checkOutput("rot_ch0_beats", recv[0], 2 * BL);
    checkOutput("rot_ch1_beats", recv[1], BL);
    checkOutput("rot_ch2_beats", recv[2], BL);
    checkOutput("rot_ch3_beats", recv[3], BL);

    $display("[TB] skip disabled channels");
    doReset();
    n = 0;
    for (int i = 0; i < 18; i++) begin
      tick(8'(n), 1'b1, 4'b1010, 4'hf, a);
      if (a) n++;
    end
    checkOutput("skip_ch1_beats", recv[1], 2 * BL);
    checkOutput("skip_ch3_beats", recv[3], BL);
    checkOutput("skip_ch0_ch2_beats", recv[0] + recv[2], 0);

    $display("[TB] backpressure mid-burst");
    doReset();
    n = 0;
    for (int i = 0; i < 10 && n < 2; i++) begin
      tick(8'(n), 1'b1, 4'hf, 4'hf, a);
      if (a) n++;
    end
    checkOutput("bp_setup_beats", n, 2);
    for (int i = 0; i < 5; i++) begin
      tick(8'(n), 1'b1, 4'hf, 4'h0, a);
      if (a) n++;
      checkOutput("bp_data_hold", out_data, 8'h01);
      checkOutput("bp_valid_hold", out_valid, 4'b0001);
    end
    for (int i = 0; i < 20; i++) begin
      tick(8'(n), (n < BL), 4'hf, 4'hf, a);
      if (a) n++;
    end
    checkOutput("bp_ch0_beats", recv[0], BL);
    checkOutput("bp_total_beats", recv[0] + recv[1] + recv[2] + recv[3], BL);

    $display("[TB] empty mask and mask change mid-burst");
    doReset();
    for (int i = 0; i < 6; i++) begin
      tick(8'h00, 1'b1, 4'h0, 4'hf, a);
      checkOutput("empty_busy", busy, 0);
      checkOutput("empty_accept", a, 0);
    end
    n = 0;
    for (int i = 0; i < 10 && n < 1; i++) begin
      tick(8'(n), 1'b1, 4'h1, 4'hf, a);
      if (a) n++;
    end
    for (int i = 0; i < 14; i++) begin
      tick(8'(n), (n < BL), 4'h0, 4'hf, a);
      if (a) n++;
    end
    checkOutput("maskchg_ch0_beats", recv[0], BL);
    checkOutput("maskchg_idle_busy", busy, 0);

    $display("[TB] asynchronous reset mid-burst");
    doReset();
    n = 0;
    for (int i = 0; i < 10 && n < 2; i++) begin
      tick(8'(n), 1'b1, 4'hf, 4'h0, a);
      if (a) n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_in_ready", in_ready, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_out_data", out_data, 0);
    checkOutput("midrst_cur_sel", cur_sel, 0);
    doReset();
    for (int i = 0; i < 8; i++) tick(8'(i + 8'h40), 1'b1, 4'b1100, 4'hf, a);
    checkOutput("postrst_ch2_beats", recv[2], BL);

    $display("[TB] randomized traffic");
    for (int s = 0; s < 3; s++) begin
      doReset();
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < 250; i++)
        tick(8'($urandom), ($urandom_range(0, 3) != 0), m, 4'($urandom), a);
      for (int i = 0; i < 10; i++) tick(8'h00, 1'b0, m, 4'hf, a);
      checkOutput("rand_drained", pend.size(), 0);
      checkOutput("rand_progress", (recv[0] + recv[1] + recv[2] + recv[3]) > 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_rr_scheduler.md
# demux_rr_scheduler

Round-robin burst scheduler that drives a 1-to-4 demultiplexer: it accepts a single valid/ready input stream and routes fixed-length bursts to one of four output channels at a time, rotating among channels enabled by a mask. It owns the select lines and a one-entry output register, so downstream channels see registered, one-hot valid with a shared data bus. It sits between a single producer and four consumers and replaces free-running select logic around the plain 1-to-4 demux.

## Interface
- DATA_W, 8, width of data path
- BURST_LEN, 4, beats per burst per channel; legal range 1..256
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- in_data  in  DATA_W  producer data
- in_valid  in  1  producer beat valid
- in_ready  out  1  scheduler accepts beat when in_valid && in_ready
- en_mask  in  4  channel enable; bit i enables channel i
- out_data  out  DATA_W  shared registered data to all channels
- out_valid  out  4  one-hot; bit i = beat pending for channel i
- out_ready  in  4  channel i consumes beat when out_valid[i] && out_ready[i]
- cur_sel  out  2  channel owning current burst
- busy  out  1  high in XFER or DRAIN

## Operation
- Reset values: in_ready=0, out_valid=0, out_data=0, cur_sel=0, busy=0, state=IDLE, beat count=0, last-served pointer=3 (so first grant searches from channel 0).
- States: IDLE, XFER, DRAIN.
- IDLE: if en_mask==0 stay. Else pick first enabled channel searching last+1, last+2, ... (mod 4); load cur_sel, clear count, go XFER. en_mask sampled only here.
- XFER: hold register empty or drained this cycle (out_ready[cur_sel]) -> in_ready=1. Accepted beat loads out_data, sets out_valid[cur_sel], count++. On acceptance of beat BURST_LEN-1 (count==BURST_LEN-1) go DRAIN; in_ready drops next cycle.
- DRAIN: in_ready=0; when hold register empty (or emptied this cycle) update last-served=cur_sel, go IDLE.
- Hold register: set on accept, cleared on out_ready[cur_sel] without simultaneous accept; simultaneous drain+accept replaces data, out_valid stays high.
- out_valid never asserted for any bit other than cur_sel; out_data stable while out_valid high and out_ready low.
- en_mask changes mid-burst: no effect until next IDLE. Disabling the channel being served does not abort the burst.
- Count width: clog2(BURST_LEN) bits, minimum 1; BURST_LEN=1 goes XFER->DRAIN on first beat.
- Reset mid-burst: all state returns to reset values immediately; pending beat is discarded.

## Timing
- Input-to-output latency: 1 cycle (beat accepted at edge N visible on out_data/out_valid after edge N).
- Throughput: 1 beat/cycle inside a burst with out_ready held high.
- Burst overhead: 1 IDLE cycle between bursts minimum; DRAIN lasts 1 cycle with out_ready high, longer under backpressure.
- Full burst, no backpressure: BURST_LEN+2 cycles from IDLE to IDLE.
- in_ready is a function of state, hold-register status and out_ready[cur_sel] only; no combinational path from in_valid.

## Structure
- Shared package demux_pkg: CH_N=4 constant, 2-bit channel select type, state enum {IDLE, XFER, DRAIN}.
- One sub-module: rr_pick (combinational; inputs 4-bit mask and 2-bit last pointer, outputs 2-bit grant and grant_valid).
- Rest (FSM, counter, hold register) in demux_rr_scheduler.

## Test plan
- Reset: assert rst_n=0 asynchronously mid-cycle -> all outputs at reset values before next edge; release -> IDLE, busy=0.
- Rotation: en_mask=4'b1111, in_valid=1 continuous, all out_ready=1, data 0x00.. -> bursts on channels 0,1,2,3,0; channel 0 receives 0x00-0x03, channel 1 0x04-0x07; one-hot out_valid always.
- Skip: en_mask=4'b1010 -> bursts alternate channel 1, 3, 1; out_valid[0], out_valid[2] never set.
- Backpressure: out_ready[cur_sel]=0 for 5 cycles mid-burst -> in_ready=0, out_data/out_valid unchanged; resume -> no beat lost or duplicated.
- Empty mask / mid-burst change: en_mask=0 -> stays IDLE, in_ready=0; set 4'b0001 then clear bit 0 after beat 1 -> burst completes all BURST_LEN beats on channel 0, then IDLE.
- Reset mid-burst: rst_n low after beat 2 -> out_valid=0 immediately; after release first burst goes to lowest enabled channel.
